// File: rtl/quad_pkg.sv
// quad_pkg: shared widths, direction encoding and snapshot states for the quad peripheral
package quad_pkg;
  localparam int QUAD_CNT_W = 32;
  localparam int QUAD_VEL_W = 16;
  localparam int QUAD_WIN_W = 24;
  localparam logic QUAD_FWD = 1'b0;
  localparam logic QUAD_REV = 1'b1;
  typedef enum logic [1:0] {SNAP_IDLE, SNAP_ACK, SNAP_WAIT_LOW} snap_state_t;
endpackage

// File: rtl/quad_vel_window.sv
// quad_vel_window: counts signed steps over a programmable window and publishes a saturated velocity
module quad_vel_window
  import quad_pkg::*;
#(
  parameter int VEL_W = QUAD_VEL_W,
  parameter int WIN_W = QUAD_WIN_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step,
  input  logic                    dir,
  input  logic                    clear,
  input  logic [WIN_W-1:0]        win_len,
  output logic signed [VEL_W-1:0] velocity,
  output logic                    vel_valid
);
  localparam logic signed [VEL_W:0] ACC_MAX = {2'b00, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W:0] ACC_MIN = {2'b11, {(VEL_W-1){1'b0}}};
  logic                    r_run;
  logic [WIN_W-1:0]        r_win;
  logic signed [VEL_W:0]   r_acc;
  logic signed [VEL_W:0]   w_delta;
  logic signed [VEL_W:0]   w_sum;
  logic signed [VEL_W:0]   w_sat;
  // acc never leaves the VEL_W range, so one extra bit holds any single-step overshoot
  always_comb begin
    w_delta = !step ? '0 : dir == QUAD_REV ? '1 : {{VEL_W{1'b0}}, 1'b1};
    w_sum   = r_acc + w_delta;
    w_sat   = w_sum > ACC_MAX ? ACC_MAX : w_sum < ACC_MIN ? ACC_MIN : w_sum;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_run     <= 1'b0;
      r_win     <= '0;
      r_acc     <= '0;
      velocity  <= '0;
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= 1'b0;
      if (win_len == '0) begin
        r_run <= 1'b0;
        r_win <= '0;
        r_acc <= '0;
      end else if (clear || !r_run) begin
        r_run <= 1'b1;
        r_win <= win_len - 1'b1;
        r_acc <= '0;
      end else if (r_win == '0) begin
        velocity  <= w_sat[VEL_W-1:0];
        vel_valid <= 1'b1;
        r_acc     <= '0;
        r_win     <= win_len - 1'b1;
      end else begin
        r_win <= r_win - 1'b1;
        r_acc <= w_sat;
      end
    end
  end
endmodule

// File: rtl/quad_counter.sv
// quad_counter: signed position counter, windowed velocity and four-phase snapshot of both
module quad_counter
  import quad_pkg::*;
#(
  parameter int CNT_W = QUAD_CNT_W,
  parameter int VEL_W = QUAD_VEL_W,
  parameter int WIN_W = QUAD_WIN_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enc_out,
  input  logic                    enc_dir,
  input  logic                    clear,
  input  logic [WIN_W-1:0]        win_len,
  input  logic                    snap_req,
  output logic                    snap_ack,
  output logic signed [CNT_W-1:0] snap_count,
  output logic signed [VEL_W-1:0] snap_vel,
  output logic signed [CNT_W-1:0] count,
  output logic signed [VEL_W-1:0] velocity,
  output logic                    vel_valid,
  output logic                    overflow
);
  localparam logic signed [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};
  logic                    r_enc_q;
  logic signed [CNT_W-1:0] r_count;
  logic                    r_ovf;
  snap_state_t             r_state;
  logic                    r_ack;
  logic signed [CNT_W-1:0] r_snap_count;
  logic signed [VEL_W-1:0] r_snap_vel;
  logic                    w_step;
  logic                    w_wrap;
  logic signed [CNT_W-1:0] w_delta;
  always_comb begin
    w_step  = enc_out ^ r_enc_q;
    w_wrap  = enc_dir == QUAD_REV ? r_count == CNT_MIN : r_count == CNT_MAX;
    w_delta = enc_dir == QUAD_REV ? '1 : {{(CNT_W-1){1'b0}}, 1'b1};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_enc_q <= 1'b0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_enc_q <= enc_out;
      if (clear) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (w_step) begin
        r_count <= r_count + w_delta;
        r_ovf   <= r_ovf | w_wrap;
      end
    end
  end
  // snapshot captures pre-update values so host sees the request-cycle state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= SNAP_IDLE;
      r_ack        <= 1'b0;
      r_snap_count <= '0;
      r_snap_vel   <= '0;
    end else begin
      case (r_state)
        SNAP_IDLE: if (snap_req) begin
          r_snap_count <= r_count;
          r_snap_vel   <= velocity;
          r_ack        <= 1'b1;
          r_state      <= SNAP_ACK;
        end
        SNAP_ACK: if (!snap_req) begin
          r_ack   <= 1'b0;
          r_state <= SNAP_WAIT_LOW;
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= SNAP_IDLE;
        end
      endcase
    end
  end
  quad_vel_window #(.VEL_W(VEL_W), .WIN_W(WIN_W)) u_vel (
    .clk       (clk),
    .reset     (reset),
    .step      (w_step & ~clear),
    .dir       (enc_dir),
    .clear     (clear),
    .win_len   (win_len),
    .velocity  (velocity),
    .vel_valid (vel_valid)
  );
  assign count      = r_count;
  assign overflow   = r_ovf;
  assign snap_ack   = r_ack;
  assign snap_count = r_snap_count;
  assign snap_vel   = r_snap_vel;
endmodule

// File: tb/tb_quad_counter.sv
// tb_quad_counter: directed self-checking bench; default instance plus an 8-bit instance for saturation/wrap
module tb_quad_counter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic               enc_out = 0, enc_dir = 0, clear = 0, snap_req = 0;
  logic [23:0]        win_len = '0;
  logic               snap_ack, vel_valid, overflow;
  logic signed [31:0] snap_count, count;
  logic signed [15:0] snap_vel, velocity;
  logic               b_enc = 0, b_dir = 0, b_clr = 0, b_req = 0;
  logic [23:0]        b_win = '0;
  logic               b_ack, b_vv, b_ovf;
  logic signed [7:0]  b_snap_count, b_count, b_snap_vel, b_vel;
  int errors = 0;
  int checks = 0;
  quad_counter dut (
    .clk(clk), .reset(reset), .enc_out(enc_out), .enc_dir(enc_dir), .clear(clear),
    .win_len(win_len), .snap_req(snap_req), .snap_ack(snap_ack), .snap_count(snap_count),
    .snap_vel(snap_vel), .count(count), .velocity(velocity), .vel_valid(vel_valid),
    .overflow(overflow)
  );
  quad_counter #(.CNT_W(8), .VEL_W(8)) dut_b (
    .clk(clk), .reset(reset), .enc_out(b_enc), .enc_dir(b_dir), .clear(b_clr),
    .win_len(b_win), .snap_req(b_req), .snap_ack(b_ack), .snap_count(b_snap_count),
    .snap_vel(b_snap_vel), .count(b_count), .velocity(b_vel), .vel_valid(b_vv),
    .overflow(b_ovf)
  );
  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int np;
    int first;
    logic signed [15:0] v_first;
    tick; tick;
    chk("rst_count", count, 0);
    chk("rst_velocity", velocity, 0);
    chk("rst_snap_count", snap_count, 0);
    chk("rst_snap_vel", snap_vel, 0);
    chk("rst_ack", snap_ack, 0);
    chk("rst_vv", vel_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_b_count", b_count, 0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin enc_dir = 0; enc_out = ~enc_out; tick; tick; tick; end
    chk("fwd8", count, 8);
    for (int i = 0; i < 3; i++) begin enc_dir = 1; enc_out = ~enc_out; tick; tick; tick; end
    chk("rev3", count, 5);
    enc_dir = 0; enc_out = ~enc_out; tick;
    chk("latency1", count, 6);
    for (int i = 0; i < 4; i++) begin enc_out = ~enc_out; tick; end
    chk("back2back", count, 10);
    win_len = 100; clear = 1; tick; clear = 0;
    chk("clear_count", count, 0);
    np = 0;
    for (int k = 0; k < 100; k++) begin
      enc_dir = 0; if (k % 4 == 0) enc_out = ~enc_out; tick;
      if (k < 99 && vel_valid) np++;
    end
    chk("win1_early", np, 0);
    chk("win1_vv", vel_valid, 1);
    chk("win1_vel", velocity, 25);
    np = 0;
    for (int k = 0; k < 100; k++) begin
      enc_dir = 1; if (k % 5 < 2) enc_out = ~enc_out; tick;
      if (k < 99 && vel_valid) np++;
    end
    chk("win2_early", np, 0);
    chk("win2_vv", vel_valid, 1);
    chk("win2_vel", velocity, -40);
    chk("win2_count", count, -15);
    np = 0;
    for (int k = 0; k < 99; k++) begin
      enc_dir = 0; if (k < 10) enc_out = ~enc_out; tick;
      if (vel_valid) np++;
    end
    clear = 1; enc_out = ~enc_out; tick; clear = 0;
    chk("win3_early", np, 0);
    chk("clr_term_count", count, 0);
    chk("clr_term_ovf", overflow, 0);
    chk("clr_term_vv", vel_valid, 0);
    chk("clr_term_vel", velocity, -40);
    np = 0;
    for (int k = 0; k < 100; k++) begin
      if (k < 7) enc_out = ~enc_out; tick;
      if (k < 99 && vel_valid) np++;
    end
    chk("postclr_early", np, 0);
    chk("postclr_vv", vel_valid, 1);
    chk("postclr_vel", velocity, 7);
    chk("postclr_count", count, 7);
    win_len = 0; np = 0;
    for (int k = 0; k < 1000; k++) begin tick; if (vel_valid) np++; end
    chk("win0_none", np, 0);
    chk("win0_hold", velocity, 7);
    enc_out = ~enc_out; snap_req = 1; tick;
    chk("snap_ack_rise", snap_ack, 1);
    chk("snap_count", snap_count, 7);
    chk("snap_vel", snap_vel, 7);
    chk("snap_live", count, 8);
    for (int i = 0; i < 3; i++) begin enc_out = ~enc_out; tick; end
    chk("snap_ack_held", snap_ack, 1);
    chk("snap_no_relatch", snap_count, 7);
    chk("snap_live2", count, 11);
    snap_req = 0; tick;
    chk("snap_ack_low", snap_ack, 0);
    chk("snap_stable", snap_count, 7);
    tick;
    snap_req = 1; tick;
    chk("snap2_ack", snap_ack, 1);
    chk("snap2_count", snap_count, 11);
    reset = 1; enc_out = 0; tick;
    chk("rst_ack_mid", snap_ack, 0);
    chk("rst_count_mid", count, 0);
    reset = 0; snap_req = 0;
    win_len = 10; np = 0; first = 0; v_first = '0;
    for (int k = 1; k <= 21; k++) begin
      enc_dir = 0; if (k >= 2 && k <= 4) enc_out = ~enc_out; tick;
      if (vel_valid) begin np++; if (first == 0) begin first = k; v_first = velocity; end end
    end
    chk("win10_first", first, 11);
    chk("win10_vel", v_first, 3);
    chk("win10_pulses", np, 2);
    b_win = 250; b_clr = 1; tick; b_clr = 0;
    for (int k = 0; k < 250; k++) begin
      b_dir = 0; if (k < 200) b_enc = ~b_enc; tick;
      if (k == 126) begin chk("b_max", b_count, 127); chk("b_max_ovf", b_ovf, 0); end
      if (k == 127) begin chk("b_wrap", b_count, -128); chk("b_wrap_ovf", b_ovf, 1); end
    end
    chk("b_sat_vv", b_vv, 1);
    chk("b_sat_vel", b_vel, 127);
    b_win = 0; b_clr = 1; tick; b_clr = 0;
    chk("b_clr_ovf", b_ovf, 0);
    chk("b_clr_count", b_count, 0);
    for (int k = 0; k < 128; k++) begin b_dir = 1; b_enc = ~b_enc; tick; end
    chk("b_min", b_count, -128);
    chk("b_min_ovf", b_ovf, 0);
    b_enc = ~b_enc; tick;
    chk("b_rwrap", b_count, 127);
    chk("b_rwrap_ovf", b_ovf, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/quad_counter.md
# quad_counter

Downstream consumer of the quadrature decoder's 4X pulse (`enc_out`) and direction (`enc_dir`) outputs. It keeps a signed position count, measures velocity as signed counts per programmable window, and gives the host a coherent snapshot of both through a four-phase request/acknowledge handshake. It sits between the quadrature decoder and the HBA register interface of the quad peripheral.

## Interface
Parameters:
- CNT_W, 32: position counter width, signed two's complement.
- VEL_W, 16: velocity result width, signed, saturating.
- WIN_W, 24: width of the velocity window length.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- enc_out  in  1  4X pulse from the decoder; each transition (either edge) is one quarter-count.
- enc_dir  in  1  direction from the decoder, valid in the same cycle as an `enc_out` transition; 0 = forward (+1), 1 = reverse (−1).
- clear  in  1  single-cycle pulse: zeroes position, overflow flag, window accumulator; restarts the window.
- win_len  in  WIN_W  window length in clk cycles; 0 disables velocity measurement.
- snap_req  in  1  snapshot request, level, four-phase.
- snap_ack  out  1  snapshot acknowledge.
- snap_count  out  CNT_W  position latched at snapshot.
- snap_vel  out  VEL_W  last completed velocity latched at snapshot.
- count  out  CNT_W  live position.
- velocity  out  VEL_W  last completed window result.
- vel_valid  out  1  one-cycle pulse when `velocity` updates.
- overflow  out  1  sticky; set when `count` wraps.

## Operation
- Edge detect: register `enc_q` (reset 0); step = `enc_out ^ enc_q`; `enc_q <= enc_out` every cycle.
- On step: `count` += +1 (dir 0) or −1 (dir 1), modulo 2^CNT_W.
- Overflow: wrap from max positive to min negative, or the reverse, sets `overflow`; only `clear` or `reset` clears it.
- Window: down-counter loaded with `win_len`−1 at start; accumulator `acc` (VEL_W+1 bits internally, saturating at signed VEL_W limits) adds each step.
- At terminal count 0:
  - `velocity <=` saturated `acc` including a step in that same cycle;
  - `vel_valid` pulses;
  - `acc` restarts at 0;
  - counter reloads from the current `win_len`.
- `win_len` changes take effect only at the next reload.
- `win_len` = 0: counter and `acc` held at 0, no `vel_valid`, `velocity` holds.
- Transition from 0 to nonzero: counter loads on the next cycle.
- Clear:
  - `count`, `acc`, `overflow` <= 0; window counter reloads.
  - A step in the same cycle is discarded.
  - `velocity` is not altered.
  - Clear coinciding with window terminal: no `vel_valid`.
- Snapshot FSM:
  - IDLE: `snap_req`=1 -> latch `snap_count <= count`, `snap_vel <= velocity` (pre-update values of that cycle); go ACK.
  - ACK: `snap_ack`=1; `snap_req`=0 -> WAIT_LOW.
  - WAIT_LOW: `snap_ack`=0; go IDLE. No re-latch while `snap_req` stays high in ACK.
  - Reset mid-handshake -> IDLE, `snap_ack`=0.

## Timing
- Reset values: `count`, `velocity`, `snap_count`, `snap_vel` = 0; `snap_ack`, `vel_valid`, `overflow` = 0; `enc_q` = 0; FSM IDLE; window counter loads `win_len`−1 (or holds 0 if `win_len` = 0) on the first cycle after reset.
- `enc_out` transition sampled at edge N -> `count` updated after edge N.
  - Downstream sees it at N+1: latency 1 clk.
- Back-to-back steps every cycle are counted exactly.
- Window period is exactly `win_len` cycles. `vel_valid` is registered and coincident with the new `velocity`.
- `snap_ack` rises 1 clk after `snap_req` is sampled high. `snap_count`/`snap_vel` are stable from `snap_ack` rise until the next request.
- Minimum handshake: 3 clk.

## Structure
- Shared package `quad_pkg`:
  - direction constants QUAD_FWD = 0, QUAD_REV = 1;
  - snapshot state enum SNAP_IDLE, SNAP_ACK, SNAP_WAIT_LOW;
  - default widths.
- Sub-module `quad_vel_window`: window counter, saturating accumulator, `vel_valid`. Inputs: step, dir, clear, win_len.
- Position counter and snapshot FSM stay in the top level.

## Test plan
- 8 forward transitions, dir=0, one every 3 clk -> `count` = 8; then 3 reverse -> `count` = 5.
- `win_len` = 100, 25 forward steps per window -> `vel_valid` every 100 clk with `velocity` = 25. Reverse at 40 steps/window -> −40.
- Saturation: VEL_W = 8, 200 forward steps in one window -> `velocity` = 127. Wrap: preload near max, `count` = 0x7FFFFFFF + 1 -> 0x80000000 and `overflow` = 1.
- `clear` coinciding with a step and with window terminal -> `count` = 0, `overflow` = 0, no `vel_valid`, next window full length.
- `snap_req` high while steps continue -> `snap_count` equals `count` at the request cycle, `snap_ack` after 1 clk, held until `snap_req` drops. Reset in ACK -> `snap_ack` = 0 next cycle.
- `win_len` = 0 -> no `vel_valid` for 1000 clk and `velocity` holds. Set 10 -> first `vel_valid` 11 clk later.
